decode_hazard_window: RTL and testbench

- Parametrised successor to the decode stage's fixed two-slot rd_prev/pc_prev/need_wait history.
- Keeps a DEPTH-entry shift window of destination registers issued from decode, each with a per-entry result-latency countdown.
- Answers rs1/rs2 hazard queries from the instruction currently in decode: youngest matching producer, its slot index, and whether decode must stall.
- Sits beside decode; its outputs feed the forwarding mux select and the fetch/decode stall logic.

---
 rtl/decode_hazard_window_pkg.sv | 20 ++
 rtl/decode_hazard_window_match.sv | 31 +++
 rtl/decode_hazard_window.sv | 139 +++++++++++++
 tb/tb_decode_hazard_window.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_hazard_window_pkg.sv
// Shared types and defaults for the decode-stage hazard window.
package decode_hazard_window_pkg;

  localparam int unsigned CREG_W      = 5;
  localparam int unsigned FUNC_ADDR_W = 64;
  localparam int unsigned HAZ_LAT_W   = 2;
  localparam int unsigned HAZ_DEPTH   = 2;

  typedef logic [CREG_W-1:0]      creg_addr_t;
  typedef logic [FUNC_ADDR_W-1:0] func_addr_t;

  // Default-width view of one in-flight producer slot.
  typedef struct packed {
    logic                 valid;
    creg_addr_t           rd;
    func_addr_t           pc;
    logic [HAZ_LAT_W-1:0] cnt;
  } hazard_slot_t;

endpackage

// File: rtl/decode_hazard_window_match.sv
// Youngest-match priority finder: lowest-index valid slot whose rd equals rs.
module decode_hazard_window_match
  import decode_hazard_window_pkg::*;
#(
  parameter int unsigned DEPTH = HAZ_DEPTH,
  parameter int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic [DEPTH-1:0]        valid_i,
  input  logic [DEPTH*CREG_W-1:0] rd_i,
  input  logic [DEPTH-1:0]        pend_i,
  input  creg_addr_t              rs_i,
  output logic                    hit_c,
  output logic [IDX_W-1:0]        idx_c,
  output logic                    busy_c
);

  // Scan oldest to youngest so the lowest index overwrites any older match.
  always_comb begin
    hit_c  = 1'b0;
    idx_c  = '0;
    busy_c = 1'b0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (valid_i[i] && (rd_i[i*CREG_W +: CREG_W] == rs_i) && (rs_i != '0)) begin
        hit_c  = 1'b1;
        idx_c  = IDX_W'(i);
        busy_c = pend_i[i];
      end
    end
  end

endmodule

// File: rtl/decode_hazard_window.sv
// DEPTH-slot window of recently issued destination registers with latency
// countdowns; answers rs1/rs2 forwarding and stall queries for decode.
module decode_hazard_window
  import decode_hazard_window_pkg::*;
#(
  parameter int unsigned DEPTH  = HAZ_DEPTH,
  parameter int unsigned ADDR_W = FUNC_ADDR_W,
  parameter int unsigned LAT_W  = HAZ_LAT_W,
  parameter int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     update,
  input  logic                     advance,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [CREG_W-1:0]        in_rd,
  input  logic [ADDR_W-1:0]        in_pc,
  input  logic [LAT_W-1:0]         in_lat,
  input  logic [CREG_W-1:0]        rs1,
  input  logic [CREG_W-1:0]        rs2,
  output logic                     rs1_hit,
  output logic                     rs2_hit,
  output logic [IDX_W-1:0]         rs1_idx,
  output logic [IDX_W-1:0]         rs2_idx,
  output logic                     rs1_busy,
  output logic                     rs2_busy,
  output logic                     stall,
  output logic [DEPTH*CREG_W-1:0]  rd_prev,
  output logic [DEPTH*ADDR_W-1:0]  pc_prev,
  output logic [DEPTH-1:0]         need_wait,
  output logic [IDX_W:0]           occupancy
);

  localparam int unsigned OCC_W = IDX_W + 1;

  typedef struct packed {
    logic              valid;
    creg_addr_t        rd;
    logic [ADDR_W-1:0] pc;
    logic [LAT_W-1:0]  cnt;
  } slot_t;

  slot_t slot_q [DEPTH];
  slot_t slot_d [DEPTH];

  function automatic logic [LAT_W-1:0] dec_sat(input logic [LAT_W-1:0] c);
    return (c == '0) ? '0 : c - LAT_W'(1);
  endfunction

  // Next-state: hold, flush, shift-in, or countdown only.
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      slot_d[i] = slot_q[i];
    end
    if (!update) begin
      // frozen pipeline keeps everything, including countdowns
    end else if (flush) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        slot_d[i] = '0;
      end
    end else if (advance) begin
      slot_d[0].valid = in_valid && (in_rd != '0);
      slot_d[0].rd    = in_rd;
      slot_d[0].pc    = in_pc;
      slot_d[0].cnt   = in_lat;
      for (int i = 1; i < int'(DEPTH); i++) begin
        slot_d[i]     = slot_q[i-1];
        slot_d[i].cnt = dec_sat(slot_q[i-1].cnt);
      end
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        slot_d[i].cnt = dec_sat(slot_q[i].cnt);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

  logic [DEPTH-1:0] valid_vec;
  logic [OCC_W-1:0] occ;

  // Flatten slot state for the match finders and the history outputs.
  always_comb begin
    valid_vec = '0;
    need_wait = '0;
    rd_prev   = '0;
    pc_prev   = '0;
    occ       = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      valid_vec[i]                   = slot_q[i].valid;
      need_wait[i]                   = slot_q[i].valid && (slot_q[i].cnt != '0);
      rd_prev[i*CREG_W +: CREG_W]    = slot_q[i].rd;
      pc_prev[i*ADDR_W +: ADDR_W]    = slot_q[i].pc;
      occ                            = occ + OCC_W'(slot_q[i].valid);
    end
  end

  assign occupancy = occ;

  decode_hazard_window_match #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_match_rs1 (
    .valid_i (valid_vec),
    .rd_i    (rd_prev),
    .pend_i  (need_wait),
    .rs_i    (rs1),
    .hit_c   (rs1_hit),
    .idx_c   (rs1_idx),
    .busy_c  (rs1_busy)
  );

  decode_hazard_window_match #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_match_rs2 (
    .valid_i (valid_vec),
    .rd_i    (rd_prev),
    .pend_i  (need_wait),
    .rs_i    (rs2),
    .hit_c   (rs2_hit),
    .idx_c   (rs2_idx),
    .busy_c  (rs2_busy)
  );

  assign stall = rs1_busy | rs2_busy;

endmodule

// File: tb/tb_decode_hazard_window.sv
// Directed bench for decode_hazard_window at DEPTH=4.
module tb_decode_hazard_window;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 64;
  localparam int unsigned LAT_W  = 2;
  localparam int unsigned IDX_W  = 2;

  logic                    clk;
  logic                    reset;
  logic                    update;
  logic                    advance;
  logic                    flush;
  logic                    in_valid;
  logic [4:0]              in_rd;
  logic [ADDR_W-1:0]       in_pc;
  logic [LAT_W-1:0]        in_lat;
  logic [4:0]              rs1;
  logic [4:0]              rs2;
  logic                    rs1_hit;
  logic                    rs2_hit;
  logic [IDX_W-1:0]        rs1_idx;
  logic [IDX_W-1:0]        rs2_idx;
  logic                    rs1_busy;
  logic                    rs2_busy;
  logic                    stall;
  logic [DEPTH*5-1:0]      rd_prev;
  logic [DEPTH*ADDR_W-1:0] pc_prev;
  logic [DEPTH-1:0]        need_wait;
  logic [IDX_W:0]          occupancy;

  int n_tests;
  int n_fail;

  decode_hazard_window #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .LAT_W  (LAT_W),
    .IDX_W  (IDX_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .update    (update),
    .advance   (advance),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_rd     (in_rd),
    .in_pc     (in_pc),
    .in_lat    (in_lat),
    .rs1       (rs1),
    .rs2       (rs2),
    .rs1_hit   (rs1_hit),
    .rs2_hit   (rs2_hit),
    .rs1_idx   (rs1_idx),
    .rs2_idx   (rs2_idx),
    .rs1_busy  (rs1_busy),
    .rs2_busy  (rs2_busy),
    .stall     (stall),
    .rd_prev   (rd_prev),
    .pc_prev   (pc_prev),
    .need_wait (need_wait),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [LAT_W-1:0] lat, input logic [ADDR_W-1:0] pc);
    advance  = 1'b1;
    in_valid = 1'b1;
    in_rd    = rd;
    in_lat   = lat;
    in_pc    = pc;
    @(posedge clk);
    #1;
    advance  = 1'b0;
    in_valid = 1'b0;
    in_rd    = '0;
    in_lat   = '0;
    in_pc    = '0;
  endtask

  task automatic test_reset();
    issue(5'd6, 2'd2, 64'h10);
    apply_reset();
    rs1 = 5'd6; rs2 = 5'd6; #1;
    n_tests++;
    if ({rs1_hit, rs2_hit, rs1_busy, rs2_busy, stall, rs1_idx, rs2_idx} !== 9'd0) begin
      n_fail++; $display("FAIL reset_query got %b want 0", {rs1_hit, rs2_hit, rs1_busy, rs2_busy, stall, rs1_idx, rs2_idx});
    end
    n_tests++;
    if (occupancy !== 3'd0) begin n_fail++; $display("FAIL reset_occ got %0d want 0", occupancy); end
    n_tests++;
    if ({rd_prev, pc_prev, need_wait} !== '0) begin n_fail++; $display("FAIL reset_history got %h want 0", rd_prev); end
  endtask

  task automatic test_alu_forward();
    issue(5'd5, 2'd0, 64'h8000_0000);
    rs1 = 5'd5; rs2 = 5'd0; #1;
    n_tests++;
    if (rs1_hit !== 1'b1 || rs1_idx !== 2'd0) begin
      n_fail++; $display("FAIL alu_hit got hit=%0d idx=%0d want hit=1 idx=0", rs1_hit, rs1_idx);
    end
    n_tests++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL alu_stall got %0d want 0", stall); end
    n_tests++;
    if (rd_prev[4:0] !== 5'd5 || pc_prev[63:0] !== 64'h8000_0000) begin
      n_fail++; $display("FAIL alu_slot0 got rd=%0d pc=%h want rd=5 pc=80000000", rd_prev[4:0], pc_prev[63:0]);
    end
    n_tests++;
    if (occupancy !== 3'd1) begin n_fail++; $display("FAIL alu_occ got %0d want 1", occupancy); end
  endtask

  task automatic test_load_stall();
    issue(5'd7, 2'd1, 64'h8000_0004);
    rs1 = 5'd5; rs2 = 5'd7; #1;
    n_tests++;
    if (stall !== 1'b1 || rs2_busy !== 1'b1 || rs2_idx !== 2'd0) begin
      n_fail++; $display("FAIL load_stall got stall=%0d busy=%0d idx=%0d want 1 1 0", stall, rs2_busy, rs2_idx);
    end
    n_tests++;
    if (rs1_idx !== 2'd1 || rs1_busy !== 1'b0) begin
      n_fail++; $display("FAIL load_older got idx=%0d busy=%0d want 1 0", rs1_idx, rs1_busy);
    end
    n_tests++;
    if (need_wait !== 4'b0001) begin n_fail++; $display("FAIL load_wait got %b want 0001", need_wait); end
    idle_cycle();
    n_tests++;
    if (stall !== 1'b0 || need_wait !== 4'b0000 || rs2_hit !== 1'b1) begin
      n_fail++; $display("FAIL load_release got stall=%0d wait=%b hit=%0d want 0 0000 1", stall, need_wait, rs2_hit);
    end
  endtask

  task automatic test_eviction();
    logic [19:0] exp_rd;
    apply_reset();
    issue(5'd3, 2'd0, 64'h100);
    issue(5'd4, 2'd0, 64'h104);
    issue(5'd5, 2'd0, 64'h108);
    issue(5'd6, 2'd0, 64'h10c);
    issue(5'd9, 2'd0, 64'h110);
    rs1 = 5'd3; rs2 = 5'd0; #1;
    n_tests++;
    if (rs1_hit !== 1'b0 || rs1_idx !== 2'd0) begin
      n_fail++; $display("FAIL evict_gone got hit=%0d idx=%0d want 0 0", rs1_hit, rs1_idx);
    end
    rs1 = 5'd4; #1;
    n_tests++;
    if (rs1_hit !== 1'b1 || rs1_idx !== 2'd3) begin
      n_fail++; $display("FAIL evict_oldest got hit=%0d idx=%0d want 1 3", rs1_hit, rs1_idx);
    end
    exp_rd = {5'd4, 5'd5, 5'd6, 5'd9};
    n_tests++;
    if (rd_prev !== exp_rd || occupancy !== 3'd4) begin
      n_fail++; $display("FAIL evict_window got rd=%h occ=%0d want %h 4", rd_prev, occupancy, exp_rd);
    end
  endtask

  task automatic test_shadow();
    issue(5'd8, 2'd2, 64'h200);
    issue(5'd8, 2'd0, 64'h204);
    rs1 = 5'd8; rs2 = 5'd9; #1;
    n_tests++;
    if (rs1_hit !== 1'b1 || rs1_idx !== 2'd0 || rs1_busy !== 1'b0 || stall !== 1'b0) begin
      n_fail++; $display("FAIL shadow got hit=%0d idx=%0d busy=%0d stall=%0d want 1 0 0 0", rs1_hit, rs1_idx, rs1_busy, stall);
    end
    n_tests++;
    if (need_wait !== 4'b0010) begin n_fail++; $display("FAIL shadow_wait got %b want 0010", need_wait); end
    n_tests++;
    if (rs2_idx !== 2'd2 || rs2_hit !== 1'b1) begin
      n_fail++; $display("FAIL shadow_rs2 got hit=%0d idx=%0d want 1 2", rs2_hit, rs2_idx);
    end
  endtask

  task automatic test_x0_flush();
    apply_reset();
    issue(5'd0, 2'd3, 64'h300);
    rs1 = 5'd0; rs2 = 5'd0; #1;
    n_tests++;
    if (rs1_hit !== 1'b0 || stall !== 1'b0 || need_wait !== 4'b0000 || occupancy !== 3'd0) begin
      n_fail++; $display("FAIL x0_slot got hit=%0d stall=%0d wait=%b occ=%0d want 0 0 0000 0", rs1_hit, stall, need_wait, occupancy);
    end
    issue(5'd11, 2'd1, 64'h304);
    rs1 = 5'd11; #1;
    n_tests++;
    if (stall !== 1'b1 || occupancy !== 3'd1) begin
      n_fail++; $display("FAIL preflush got stall=%0d occ=%0d want 1 1", stall, occupancy);
    end
    flush = 1'b1; advance = 1'b1; in_valid = 1'b1; in_rd = 5'd10; in_pc = 64'h308;
    @(posedge clk);
    #1;
    flush = 1'b0; advance = 1'b0; in_valid = 1'b0; in_rd = '0; in_pc = '0;
    rs1 = 5'd10; rs2 = 5'd11; #1;
    n_tests++;
    if (occupancy !== 3'd0 || rd_prev !== '0 || pc_prev !== '0 || need_wait !== '0) begin
      n_fail++; $display("FAIL flush_state got occ=%0d rd=%h wait=%b want 0 0 0", occupancy, rd_prev, need_wait);
    end
    n_tests++;
    if ({rs1_hit, rs2_hit, stall} !== 3'b000) begin
      n_fail++; $display("FAIL flush_query got %b want 000", {rs1_hit, rs2_hit, stall});
    end
  endtask

  task automatic test_freeze();
    apply_reset();
    issue(5'd12, 2'd2, 64'h400);
    rs1 = 5'd12; rs2 = 5'd0; #1;
    n_tests++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL freeze_start got %0d want 1", stall); end
    update = 1'b0; advance = 1'b1; in_valid = 1'b1; in_rd = 5'd13; in_lat = 2'd0;
    for (int c = 0; c < 3; c++) begin
      idle_cycle();
      n_tests++;
      if (stall !== 1'b1 || occupancy !== 3'd1 || rd_prev[4:0] !== 5'd12) begin
        n_fail++; $display("FAIL freeze_hold cyc=%0d got stall=%0d occ=%0d rd=%0d want 1 1 12", c, stall, occupancy, rd_prev[4:0]);
      end
    end
    update = 1'b1; advance = 1'b0; in_valid = 1'b0; in_rd = '0;
    idle_cycle();
    n_tests++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL freeze_cnt got stall=%0d want 1", stall); end
    apply_reset();
    n_tests++;
    if (stall !== 1'b0 || occupancy !== 3'd0) begin
      n_fail++; $display("FAIL reset_mid_stall got stall=%0d occ=%0d want 0 0", stall, occupancy);
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    clk = 1'b0; reset = 1'b1; update = 1'b1; advance = 1'b0; flush = 1'b0;
    in_valid = 1'b0; in_rd = '0; in_pc = '0; in_lat = '0; rs1 = '0; rs2 = '0;
    idle_cycle();
    reset = 1'b0;
    test_reset();
    test_alu_forward();
    test_load_stall();
    test_eviction();
    test_shadow();
    test_x0_flush();
    test_freeze();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
